// File: rtl/axis_packetizer_tlast.sv
// rtl/axis_packetizer_tlast.sv - AXI-Stream packetizer adding tlast every N beats with idle-timeout flush
//
// Purpose:
//   Turns an unframed sample stream into packets for a DMA S2MM engine. Each packet
//   is cfg_pkt_len beats long, with tlast on the final beat. A partial packet that
//   sees no new input for cfg_timeout cycles is closed early as a short packet.
//
// Ports:
//   aclk, aresetn         clock, asynchronous active-low reset
//   cfg_pkt_len           beats per packet (0 behaves as 1), latched at beat 1
//   cfg_timeout           idle cycles before a short-packet flush (0 = never flush)
//   s_axis_tdata/tvalid/tready              input sample stream
//   m_axis_tdata/tvalid/tready/tlast        output packet stream
//   stat_pkt_count        packets emitted (tlast handshakes), wrapping
//   stat_short_count      packets closed by timeout, wrapping
//   busy                  a packet is open or a register holds data

module axis_packetizer_tlast #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int TO_WIDTH   = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [LEN_WIDTH-1:0]  cfg_pkt_len,
    input  logic [TO_WIDTH-1:0]   cfg_timeout,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [31:0]           stat_pkt_count,
    output logic [31:0]           stat_short_count,
    output logic                  busy
);

    // Hold register: the most recently accepted beat. Because H is only vacated by
    // a release, and every non-closing release is paired with a new accept, H is
    // empty exactly when no packet is open; h_idx therefore doubles as the beat
    // counter of the open packet.
    logic [DATA_WIDTH-1:0] h_data;
    logic                  h_valid;
    logic [LEN_WIDTH-1:0]  h_idx;
    logic [LEN_WIDTH-1:0]  plen;
    logic [TO_WIDTH-1:0]   idle;

    logic                  o_free;
    logic                  hit_len;
    logic                  hit_to;
    logic                  s_hs;
    logic                  h_release;
    logic                  rel_last;
    logic                  rel_short;
    logic                  new_pkt;
    logic [LEN_WIDTH-1:0]  next_idx;
    logic [LEN_WIDTH-1:0]  cfg_len_eff;

    always_comb begin
        o_free      = !m_axis_tvalid || m_axis_tready;
        hit_len     = h_valid && (h_idx == plen);
        // >= rather than == so that lowering cfg_timeout below the running count
        // fires the flush at the next compare instead of waiting forever.
        hit_to      = h_valid && (cfg_timeout != '0) && (idle >= cfg_timeout);

        // A non-last beat in H can only move on together with its successor, so
        // readiness while H is full hinges on s_axis_tvalid when neither the
        // length nor the timeout condition would release it on its own.
        s_axis_tready = aresetn &&
                        (!h_valid || (o_free && (hit_len || hit_to || s_axis_tvalid)));
        s_hs        = s_axis_tvalid && s_axis_tready;

        h_release   = h_valid && o_free && (hit_len || s_hs || hit_to);
        // Length match wins; otherwise a concurrent accept keeps the packet open;
        // only a pure timeout closes it short.
        rel_last    = hit_len || !s_hs;
        rel_short   = h_release && !hit_len && !s_hs;

        // The accepted beat starts a packet when none is open, or when the open one
        // is being closed in this same cycle.
        new_pkt     = !h_valid || (h_release && rel_last);
        next_idx    = new_pkt ? LEN_WIDTH'(1) : h_idx + LEN_WIDTH'(1);
        cfg_len_eff = (cfg_pkt_len == '0) ? LEN_WIDTH'(1) : cfg_pkt_len;
    end

    // Hold register, packet length latch and beat counter.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            h_data  <= '0;
            h_valid <= 1'b0;
            h_idx   <= '0;
            plen    <= LEN_WIDTH'(1);
        end else begin
            if (s_hs) begin
                h_data  <= s_axis_tdata;
                h_valid <= 1'b1;
                h_idx   <= next_idx;
                if (new_pkt) begin
                    plen <= cfg_len_eff;
                end
            end else if (h_release) begin
                h_valid <= 1'b0;
                h_idx   <= '0;
            end
        end
    end

    // Output register; contents only change on a release, which requires O to be
    // empty or handshaking, so tdata/tlast stay put while stalled.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            if (h_release) begin
                m_axis_tdata  <= h_data;
                m_axis_tlast  <= rel_last;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

    // Idle counter: counts cycles a beat has sat in H without a successor,
    // saturating at the live timeout value.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            idle <= '0;
        end else begin
            if (s_hs || !h_valid || h_release) begin
                idle <= '0;
            end else if (idle < cfg_timeout) begin
                idle <= idle + TO_WIDTH'(1);
            end
        end
    end

    // Statistics.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stat_pkt_count   <= '0;
            stat_short_count <= '0;
        end else begin
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                stat_pkt_count <= stat_pkt_count + 32'd1;
            end
            if (rel_short) begin
                stat_short_count <= stat_short_count + 32'd1;
            end
        end
    end

    assign busy = h_valid || m_axis_tvalid;

endmodule

// File: tb/tb_axis_packetizer_tlast.sv
// tb/tb_axis_packetizer_tlast.sv - self-checking bench for axis_packetizer_tlast

module tb_axis_packetizer_tlast;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b1;
    logic [15:0] cfg_pkt_len = 16'd4;
    logic [15:0] cfg_timeout = 16'd0;
    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        m_tlast;
    logic [31:0] stat_pkt;
    logic [31:0] stat_short;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [31:0] in_q[$];
    int          in_c[$];
    logic [31:0] out_q[$];
    logic        out_l[$];
    int          out_c[$];

    axis_packetizer_tlast #(.DATA_WIDTH(32), .LEN_WIDTH(16), .TO_WIDTH(16)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cfg_pkt_len(cfg_pkt_len), .cfg_timeout(cfg_timeout),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast),
        .stat_pkt_count(stat_pkt), .stat_short_count(stat_short), .busy(busy)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    // Handshake recorder, sampled mid-cycle while inputs and outputs are stable.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (s_tvalid && s_tready) begin
                in_q.push_back(s_tdata);
                in_c.push_back(cyc);
            end
            if (m_tvalid && m_tready) begin
                out_q.push_back(m_tdata);
                out_l.push_back(m_tlast);
                out_c.push_back(cyc);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_queues();
        in_q.delete(); in_c.delete();
        out_q.delete(); out_l.delete(); out_c.delete();
    endtask

    task automatic do_reset();
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        repeat (3) step();
        clear_queues();
        aresetn = 1'b1;
        step();
    endtask

    // Offers n random words; vpct/rpct are the per-cycle probabilities (percent) of
    // presenting a new input word and of m_tready. Counts stall-rule violations and
    // cycles where a valid input was refused.
    task automatic send(input int n, input int vpct, input int rpct,
                        output int stall_err, output int not_ready);
        int acc = 0;
        int guard = 0;
        bit hs;
        logic pv, pr, pl;
        logic [31:0] pd;
        stall_err = 0;
        not_ready = 0;
        while (acc < n && guard < 5000) begin
            guard++;
            if (!s_tvalid && ($urandom_range(99) < vpct)) begin
                s_tvalid = 1'b1;
                s_tdata  = $urandom;
            end
            m_tready = ($urandom_range(99) < rpct);
            #1;
            hs = s_tvalid && s_tready;
            if (s_tvalid && !s_tready) not_ready++;
            pv = m_tvalid; pr = m_tready; pd = m_tdata; pl = m_tlast;
            @(posedge aclk);
            #1;
            if (hs) begin
                acc++;
                s_tvalid = 1'b0;
            end
            if (pv && !pr && (!m_tvalid || m_tdata !== pd || m_tlast !== pl)) stall_err++;
        end
        s_tvalid = 1'b0;
        if (acc < n) begin
            n_tests++; n_fail++;
            $display("FAIL send_budget: accepted %0d of %0d beats", acc, n);
        end
    endtask

    task automatic drain(input int cycles);
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        repeat (cycles) step();
    endtask

    // Reference framing: packets of the given lengths, in order.
    function automatic bit model_last(int idx, int lens[$]);
        int pos = 0;
        foreach (lens[k]) begin
            pos += lens[k];
            if (idx == pos - 1) return 1'b1;
            if (idx < pos - 1) return 1'b0;
        end
        return 1'b0;
    endfunction

    task automatic test_reset();
        aresetn  = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 32'hdead_beef;
        m_tready = 1'b1;
        #1;
        repeat (2) step();
        n_tests++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %b want 0", s_tready); end
        n_tests++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_out: tvalid %b tlast %b tdata %h want all 0", m_tvalid, m_tlast, m_tdata); end
        n_tests++; if (stat_pkt !== 32'd0 || stat_short !== 32'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_stats: pkt %0d short %0d busy %b want 0", stat_pkt, stat_short, busy); end
        s_tvalid = 1'b0;
        clear_queues();
        aresetn = 1'b1;
        step();
        n_tests++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL reset_release_tready: got %b want 1", s_tready); end
    endtask

    task automatic test_basic();
        int se, nr;
        int lens[$] = '{4, 4};
        do_reset();
        cfg_pkt_len = 16'd4; cfg_timeout = 16'd0;
        send(8, 100, 100, se, nr);
        drain(6);
        n_tests++; if (out_q.size() !== 8) begin n_fail++; $display("FAIL basic_count: got %0d want 8", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < in_q.size(); i++) begin
            n_tests++;
            if (out_q[i] !== in_q[i] || out_l[i] !== model_last(i, lens)) begin
                n_fail++; $display("FAIL basic_beat%0d: data %h last %b want %h %b", i, out_q[i], out_l[i], in_q[i], model_last(i, lens));
            end
        end
        n_tests++; if (nr !== 0) begin n_fail++; $display("FAIL basic_throughput: %0d refused cycles want 0", nr); end
        n_tests++; if (stat_pkt !== 32'd2) begin n_fail++; $display("FAIL basic_pkt_count: got %0d want 2", stat_pkt); end
        if (out_c.size() == 8 && in_c.size() == 8) begin
            n_tests++; if (out_c[3] - in_c[3] !== 2) begin n_fail++; $display("FAIL basic_latency4: got %0d want 2", out_c[3] - in_c[3]); end
            n_tests++; if (out_c[7] - in_c[7] !== 2) begin n_fail++; $display("FAIL basic_latency8: got %0d want 2", out_c[7] - in_c[7]); end
        end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b want 0", busy); end
    endtask

    task automatic test_timeout();
        int se, nr;
        int to = 16;
        int lens[$] = '{3, 4};
        do_reset();
        cfg_pkt_len = 16'd4; cfg_timeout = 16'(to);
        send(3, 100, 100, se, nr);
        drain(40);
        n_tests++; if (out_q.size() !== 3) begin n_fail++; $display("FAIL to_count: got %0d want 3", out_q.size()); end
        if (out_c.size() == 3 && in_c.size() == 3) begin
            n_tests++; if (out_c[2] - in_c[2] !== to + 2) begin
                n_fail++; $display("FAIL to_latency: got %0d want %0d", out_c[2] - in_c[2], to + 2); end
        end
        n_tests++; if (stat_short !== 32'd1) begin n_fail++; $display("FAIL to_short_count: got %0d want 1", stat_short); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL to_busy: got %b want 0", busy); end
        send(4, 100, 100, se, nr);
        drain(10);
        n_tests++; if (out_q.size() !== 7) begin n_fail++; $display("FAIL to_count2: got %0d want 7", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < in_q.size(); i++) begin
            n_tests++;
            if (out_q[i] !== in_q[i] || out_l[i] !== model_last(i, lens)) begin
                n_fail++; $display("FAIL to_beat%0d: data %h last %b want %h %b", i, out_q[i], out_l[i], in_q[i], model_last(i, lens));
            end
        end
        n_tests++; if (stat_pkt !== 32'd2 || stat_short !== 32'd1) begin
            n_fail++; $display("FAIL to_stats: pkt %0d short %0d want 2 1", stat_pkt, stat_short); end
    endtask

    task automatic test_random();
        int se, nr, bad = 0;
        int lens[$];
        for (int k = 0; k < 20; k++) lens.push_back(5);
        do_reset();
        cfg_pkt_len = 16'd5; cfg_timeout = 16'd0;
        send(100, 50, 50, se, nr);
        drain(10);
        n_tests++; if (out_q.size() !== 100) begin n_fail++; $display("FAIL rand_count: got %0d want 100", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < in_q.size(); i++) begin
            if (out_q[i] !== in_q[i] || out_l[i] !== model_last(i, lens)) begin
                bad++;
                if (bad <= 5) $display("FAIL rand_beat%0d: data %h last %b want %h %b", i, out_q[i], out_l[i], in_q[i], model_last(i, lens));
            end
        end
        n_tests++; if (bad !== 0) n_fail++;
        n_tests++; if (se !== 0) begin n_fail++; $display("FAIL rand_stall_hold: %0d violations want 0", se); end
        n_tests++; if (stat_pkt !== 32'd20) begin n_fail++; $display("FAIL rand_pkt_count: got %0d want 20", stat_pkt); end
    endtask

    task automatic test_len01();
        int se, nr;
        for (int l = 0; l < 2; l++) begin
            do_reset();
            cfg_pkt_len = 16'(l); cfg_timeout = 16'd0;
            send(6, 100, 100, se, nr);
            drain(5);
            n_tests++; if (out_q.size() !== 6) begin n_fail++; $display("FAIL len%0d_count: got %0d want 6", l, out_q.size()); end
            for (int i = 0; i < out_q.size() && i < in_q.size(); i++) begin
                n_tests++;
                if (out_q[i] !== in_q[i] || out_l[i] !== 1'b1) begin
                    n_fail++; $display("FAIL len%0d_beat%0d: data %h last %b want %h 1", l, i, out_q[i], out_l[i], in_q[i]);
                end
            end
            n_tests++; if (nr !== 0) begin n_fail++; $display("FAIL len%0d_throughput: %0d refused want 0", l, nr); end
            n_tests++; if (stat_pkt !== 32'd6) begin n_fail++; $display("FAIL len%0d_pkt_count: got %0d want 6", l, stat_pkt); end
        end
    endtask

    task automatic test_len_change();
        int se, nr;
        int lens[$] = '{4, 2, 2};
        do_reset();
        cfg_pkt_len = 16'd4; cfg_timeout = 16'd0;
        send(2, 100, 100, se, nr);
        cfg_pkt_len = 16'd2;
        send(6, 100, 100, se, nr);
        drain(6);
        n_tests++; if (out_q.size() !== 8) begin n_fail++; $display("FAIL lenchg_count: got %0d want 8", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < in_q.size(); i++) begin
            n_tests++;
            if (out_q[i] !== in_q[i] || out_l[i] !== model_last(i, lens)) begin
                n_fail++; $display("FAIL lenchg_beat%0d: data %h last %b want %h %b", i, out_q[i], out_l[i], in_q[i], model_last(i, lens));
            end
        end
        n_tests++; if (stat_pkt !== 32'd3) begin n_fail++; $display("FAIL lenchg_pkt_count: got %0d want 3", stat_pkt); end
    endtask

    task automatic test_reset_mid();
        int se, nr;
        int lens[$] = '{4};
        do_reset();
        cfg_pkt_len = 16'd4; cfg_timeout = 16'd0;
        send(2, 100, 0, se, nr);
        m_tready = 1'b0;
        repeat (2) step();
        n_tests++; if (m_tvalid !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_prereset: tvalid %b busy %b want 1 1", m_tvalid, busy); end
        aresetn = 1'b0;
        #1;
        n_tests++; if (m_tvalid !== 1'b0 || busy !== 1'b0 || s_tready !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: tvalid %b busy %b tready %b want 0 0 0", m_tvalid, busy, s_tready); end
        n_tests++; if (stat_pkt !== 32'd0 || stat_short !== 32'd0) begin
            n_fail++; $display("FAIL mid_reset_stats: pkt %0d short %0d want 0 0", stat_pkt, stat_short); end
        repeat (2) step();
        aresetn = 1'b1;
        step();
        send(4, 100, 100, se, nr);
        drain(6);
        n_tests++; if (out_q.size() !== 4 || in_q.size() !== 6) begin
            n_fail++; $display("FAIL mid_count: out %0d in %0d want 4 6", out_q.size(), in_q.size()); end
        for (int i = 0; i < out_q.size() && i + 2 < in_q.size(); i++) begin
            n_tests++;
            if (out_q[i] !== in_q[i + 2] || out_l[i] !== model_last(i, lens)) begin
                n_fail++; $display("FAIL mid_beat%0d: data %h last %b want %h %b", i, out_q[i], out_l[i], in_q[i + 2], model_last(i, lens));
            end
        end
        n_tests++; if (stat_pkt !== 32'd1) begin n_fail++; $display("FAIL mid_pkt_count: got %0d want 1", stat_pkt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_random();
        test_len01();
        test_len_change();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
